// File: rtl/matmul_job_arbiter_if.sv
// Requester and matrix_mul signal bundle for matmul_job_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface matmul_job_arbiter_if #(
    parameter int unsigned DW = 8
);
    logic [1:0]        rq_valid;
    logic [1:0]        rq_ready;
    logic [4*DW-1:0]   rq0_a;
    logic [4*DW-1:0]   rq0_b;
    logic [4*DW-1:0]   rq1_a;
    logic [4*DW-1:0]   rq1_b;
    logic [1:0]        rsp_valid;
    logic [8*DW-1:0]   rsp_c;
    logic              rsp_err;
    logic              mm_start;
    logic [4*DW-1:0]   mm_a;
    logic [4*DW-1:0]   mm_b;
    logic [8*DW-1:0]   mm_c;
    logic              mm_done;

    modport slave (
        input  rq_valid, rq0_a, rq0_b, rq1_a, rq1_b, mm_c, mm_done,
        output rq_ready, rsp_valid, rsp_c, rsp_err, mm_start, mm_a, mm_b
    );

    modport master (
        output rq_valid, rq0_a, rq0_b, rq1_a, rq1_b, mm_c, mm_done,
        input  rq_ready, rsp_valid, rsp_c, rsp_err, mm_start, mm_a, mm_b
    );
endinterface

// File: rtl/matmul_job_arbiter.sv
// Round-robin arbiter sharing one 2x2 matrix_mul between two requesters,
// one job in flight, with stale-done rejection and a WAIT timeout.
module matmul_job_arbiter #(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_job_arbiter_if.slave   bus,
    output logic                  busy,
    output logic [15:0]           jobs_done
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          rr_ptr;
    logic          gnt;
    logic          armed;
    logic [CW-1:0] tcnt;

    logic          take;
    logic          win;

    // Winner selection: a lone requester always wins, contention goes to rr_ptr.
    always_comb begin
        take = 1'b0;
        win  = 1'b0;
        case (bus.rq_valid)
            2'b01:   begin take = 1'b1; win = 1'b0;   end
            2'b10:   begin take = 1'b1; win = 1'b1;   end
            2'b11:   begin take = 1'b1; win = rr_ptr; end
            default: begin take = 1'b0; win = 1'b0;   end
        endcase
        bus.rq_ready = 2'b00;
        if (state == IDLE && take) begin
            bus.rq_ready = win ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            gnt           <= 1'b0;
            armed         <= 1'b0;
            tcnt          <= '0;
            busy          <= 1'b0;
            jobs_done     <= 16'd0;
            bus.mm_start  <= 1'b0;
            bus.mm_a      <= '0;
            bus.mm_b      <= '0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_c     <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.mm_start  <= 1'b0;
            bus.rsp_valid <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        bus.mm_a     <= win ? bus.rq1_a : bus.rq0_a;
                        bus.mm_b     <= win ? bus.rq1_b : bus.rq0_b;
                        gnt          <= win;
                        rr_ptr       <= ~win;
                        busy         <= 1'b1;
                        bus.mm_start <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    armed <= 1'b0;
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    tcnt <= tcnt + CW'(1);
                    // Arm only after done has been seen low, so a level left over
                    // from the previous job cannot complete this one.
                    if (!armed && !bus.mm_done) begin
                        armed <= 1'b1;
                    end
                    if (armed && bus.mm_done) begin
                        bus.rsp_c     <= bus.mm_c;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= gnt ? 2'b10 : 2'b01;
                        jobs_done     <= jobs_done + 16'd1;
                        state         <= RESP;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        bus.rsp_c     <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= gnt ? 2'b10 : 2'b01;
                        jobs_done     <= jobs_done + 16'd1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/matmul_job_arbiter.md
Name: matmul_job_arbiter

Overview:
- Shares the single 2x2 matrix_mul datapath between two requesters (e.g. VIO-driven host port and an on-chip test source).
- Accepts one job at a time, then:
  - round-robin arbitrates between the requesters;
  - latches operands and issues a one-cycle start to matrix_mul;
  - waits for done, with timeout protection;
  - returns C and a response pulse to the granted requester.
- Sits between requester logic and matrix_mul in top-level integration.

Parameters:
- DW, 8: operand element width; results are 2*DW.
- TIMEOUT, 64: maximum WAIT cycles before the job is aborted with error; must be >= 2.
- CW, $clog2(TIMEOUT+1): timeout counter width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rq_valid  in  2  per-requester job request; operands must be held stable while valid and not ready.
- rq_ready  out  2  combinational accept; at most one bit set.
- rq0_a, rq1_a  in  4*DW  packed {A3,A2,A1,A0}, row-major (A0=a00, A1=a01, A2=a10, A3=a11).
- rq0_b, rq1_b  in  4*DW  packed {B3,B2,B1,B0}, same ordering.
- rsp_valid  out  2  one-cycle pulse to the requester whose job completed.
- rsp_c  out  8*DW  packed {C3,C2,C1,C0}; held until the next response.
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout; rsp_c is then all zero.
- busy  out  1  high in every state except IDLE.
- jobs_done  out  16  count of completed jobs (both ok and err); wraps 0xFFFF->0.
- mm_start  out  1  one-cycle start pulse to matrix_mul.
- mm_a  out  4*DW  operand A to matrix_mul; held from ISSUE through WAIT.
- mm_b  out  4*DW  operand B to matrix_mul; held from ISSUE through WAIT.
- mm_c  in  8*DW  result {C3..C0} from matrix_mul.
- mm_done  in  1  completion from matrix_mul; may remain high after a job.

Behaviour:
- Reset (async, any state), all registers return to:
  - state=IDLE, rr_ptr=0.
  - mm_start, mm_a, mm_b, rsp_valid, rsp_c, rsp_err, jobs_done, busy all 0.
  - armed=0, timeout counter=0.
  - An in-flight job is discarded with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner selection: if exactly one rq_valid bit is set, that requester wins. If both are set, requester rr_ptr wins.
  - rq_ready[winner]=1 combinationally.
  - On that edge: latch winner's a/b into mm_a/mm_b, record gnt, set rr_ptr = ~winner, go to ISSUE.
  - rq_ready is 0 in all other states.
- ISSUE (1 cycle): mm_start=1, armed<=0, counter<=0, go to WAIT.
- WAIT:
  - Each cycle, counter increments.
  - If !armed and !mm_done: armed<=1. This ignores a done level left over from a previous job.
  - If armed and mm_done: rsp_c<=mm_c, rsp_err<=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_c<=0, rsp_err<=1, go to RESP.
  - Done takes priority over timeout in the same cycle.
- RESP (1 cycle): rsp_valid[gnt]=1, jobs_done+=1, go to IDLE.
- Latency and throughput:
  - With acceptance at cycle T: mm_start is high at T+1.
  - If mm_done is first qualifying-high at cycle D: rsp_valid is high at D+1.
  - The next acceptance is possible at D+2.
- Fairness:
  - With both requesting continuously, grants alternate 0,1,0,1.
  - A lone requester is granted back-to-back.
- rq_valid dropped before acceptance: no job is queued and there is no side effect.
- mm_c is sampled only in WAIT with armed and mm_done set; it is ignored elsewhere.

Test Plan:
- Bench model of matrix_mul with programmable latency L and done held high until the next start.
- Basic: req0 with A={1,2,3,4}, B={5,6,7,8}, L=3.
  - Requires mm_start at T+1.
  - Requires rsp_valid=2'b01 with rsp_c {C0..C3}={19,22,43,50}, rsp_err=0, jobs_done=1.
- Stale done: back-to-back jobs for req1 with done still high from the previous job.
  - Second job must not complete until done has gone low then high.
  - Second job: A={2,0,0,2}, B={3,4,5,6} -> {6,8,10,12}.
- Contention: both valid from reset for 4 jobs.
  - Grant order must be 0,1,0,1.
  - rq_ready is never 2'b11.
  - rsp_valid matches each grant.
- Timeout: TIMEOUT=8, model never raises done.
  - Requires rsp_valid at T+10 with rsp_err=1, rsp_c=0.
  - Next job then succeeds normally.
- Reset mid-WAIT: assert rst asynchronously (not on a clock edge).
  - Outputs must go to 0 immediately, with no rsp_valid.
  - After release, req0 is served first even if both requesters are valid.
